// File: rtl/regfile_wb_queue.sv
// Regfile write-port sequencer: merges ALU and memory results through one
// shared in-order FIFO and reports pending writes for RAW hazard stalls.
module regfile_wb_queue #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic [4:0]        mem_rd,
    input  logic [DWIDTH-1:0] mem_data,
    output logic              mem_ready,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [DWIDTH-1:0] alu_data,
    output logic              alu_ready,
    output logic [4:0]        rd,
    output logic [DWIDTH-1:0] writedata,
    output logic              RegWen,
    input  logic [4:0]        q_rs1,
    input  logic [4:0]        q_rs2,
    output logic              q_hit1,
    output logic              q_hit2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]        ent_rd   [DEPTH];
    logic [DWIDTH-1:0] ent_data [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     alu_slot;
    logic [PW-1:0]     off;
    logic [CW-1:0]     count;
    logic [CW-1:0]     free;
    logic              mem_push;
    logic              alu_push;
    logic              pop;
    logic              hit1;
    logic              hit2;

    // Space comes from the registered count only; a same-cycle pop never
    // frees a slot early, and mem owns the last slot.
    assign free      = FULL - count;
    assign mem_ready = (free != '0);
    assign alu_ready = (free >= CW'(2)) | ((free == CW'(1)) & ~mem_valid);

    assign mem_push = mem_valid & mem_ready & (mem_rd != 5'd0);
    assign alu_push = alu_valid & alu_ready & (alu_rd != 5'd0);
    assign pop      = (count != '0);
    assign alu_slot = wr_ptr + PW'(mem_push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd        <= '0;
            writedata <= '0;
            RegWen    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd[i]   <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (mem_push) begin
                ent_rd[wr_ptr]   <= mem_rd;
                ent_data[wr_ptr] <= mem_data;
            end
            if (alu_push) begin
                ent_rd[alu_slot]   <= alu_rd;
                ent_data[alu_slot] <= alu_data;
            end
            wr_ptr <= wr_ptr + PW'(mem_push) + PW'(alu_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
            RegWen <= pop;
            if (pop) begin
                rd        <= ent_rd[rd_ptr];
                writedata <= ent_data[rd_ptr];
            end
        end
    end

    // An entry is live when its distance from the head is below count.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (CW'(off) < count) begin
                if (ent_rd[i] == q_rs1) hit1 = 1'b1;
                if (ent_rd[i] == q_rs2) hit2 = 1'b1;
            end
        end
    end

    assign q_hit1 = (q_rs1 != 5'd0) & (hit1 | (RegWen & (rd == q_rs1)));
    assign q_hit2 = (q_rs2 != 5'd0) & (hit2 | (RegWen & (rd == q_rs2)));

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writer side of the register file's single write port.
- Accepts retiring results from two producers:
  - the single-cycle ALU path;
  - the memory/long-latency path.
- Queues both producers in program order in a shared FIFO.
- Drives rd/writedata/RegWen, one write per cycle.
- Answers pending-write queries so decode can stall on RAW hazards until the regfile holds the value.

Parameters:
- DWIDTH, 32, data width of results and writedata.
- DEPTH, 4, shared FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_valid  in  1  memory-path result valid.
- mem_rd  in  5  memory-path destination register.
- mem_data  in  DWIDTH  memory-path result.
- mem_ready  out  1  memory-path result accepted when valid&ready.
- alu_valid  in  1  ALU result valid.
- alu_rd  in  5  ALU destination register.
- alu_data  in  DWIDTH  ALU result.
- alu_ready  out  1  ALU result accepted when valid&ready.
- rd  out  5  regfile write address.
- writedata  out  DWIDTH  regfile write data.
- RegWen  out  1  regfile write enable, one-cycle pulse per write.
- q_rs1  in  5  hazard query address 1.
- q_rs2  in  5  hazard query address 2.
- q_hit1  out  1  write to q_rs1 pending.
- q_hit2  out  1  write to q_rs2 pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty, count=0, pointers=0.
  - RegWen=0, rd=0, writedata=0.
  - Reset mid-operation discards all queued entries; no RegWen pulse follows reset release until a new push.
- Free slots, computed from the registered count only:
  - free = DEPTH - count.
  - A pop in the same cycle does not create extra space.
- Ready rules:
  - mem_ready = (free >= 1).
  - alu_ready = (free >= 2) | (free == 1 & !mem_valid).
  - mem always has priority on the last slot.
- Push ordering:
  - Both accepted in one cycle: mem entry enqueued first (older instruction), alu entry second.
  - count increases by up to 2 per cycle.
- x0 filter: an accepted handshake with rd==0 completes normally (ready honoured) but is not enqueued and consumes no slot.
- Pop:
  - Each edge, if count>0 at the start of the cycle, head entry moves to the output register with RegWen=1.
  - Otherwise RegWen=0; rd/writedata hold their previous values.
  - Same-cycle push and pop are allowed: count_next = count + pushes - pop.
- Latency:
  - Handshake at edge N into an empty queue gives RegWen=1 with that rd/data during the cycle after edge N+1.
  - The regfile captures it at edge N+2.
- Throughput is one write per cycle; sustained dual push backpressures via the ready signals.
- Ordering: regfile writes occur strictly in enqueue order; two writes to the same rd retire oldest first.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Hazard query (combinational):
  - q_hitX = (q_rsX != 0) & (any valid FIFO entry has rd == q_rsX, or (RegWen & rd == q_rsX)).
  - x0 never hits.

Test Plan:
- Reset, then single ALU push alu_rd=5, data=0xDEADBEEF at edge N -> RegWen=1, rd=5, writedata=0xDEADBEEF for exactly one cycle after edge N+1; then RegWen=0 with rd/data held.
- Same-cycle mem_rd=3 data=0x11 and alu_rd=4 data=0x22 into empty queue -> two consecutive RegWen pulses, rd=3 then rd=4; q_hit1 for q_rs1=4 stays high until the rd=4 pulse ends.
- Fill with no pops (counter-driven pushes faster than drain) until free==1 with both valid -> mem_ready=1, alu_ready=0; at free==0 both ready=0; then pops drain in exact enqueue order.
- Push alu_rd=0 data=0xFFFF -> handshake completes, count unchanged, no RegWen pulse; q_rs1=0 -> q_hit1=0.
- Two ALU writes to rd=7 (0xA then 0xB) -> pulses in order 0xA, 0xB; q_hit for 7 high until the second pulse completes.
- Assert rst_n low asynchronously with 3 entries queued and RegWen=1 -> RegWen=0, rd=0, writedata=0 immediately; after release, no writes until a new push.
